ioctl_sdram_loader: RTL and testbench

- Bridges the HPS ioctl byte download stream to one 16-bit SDRAM write port using the toggle req/ack handshake.
- Packs byte pairs into full-word writes, which halves SDRAM traffic compared with per-byte writes.
- Flushes a dangling byte when addresses jump or the download ends.
- Captures DIP-switch bytes into a register bank and reports load completion.
- Sits between hps_io and the sdram controller's port 0, replacing the inline per-byte write logic in the emu top.

---
 rtl/loader_pkg.sv | 30 +++
 rtl/toggle_req_port.sv | 47 ++++
 rtl/ioctl_sdram_loader.sv | 227 ++++++++++++++++++++++
 tb/tb_ioctl_sdram_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types for the ioctl -> SDRAM loader.
//   loader_state_e : loader FSM states
//   pend_wr_t      : one SDRAM write request {addr, din, wrl, wrh}
//   word_addr()    : byte address -> SDRAM word address with base offset
package loader_pkg;

   localparam logic [7:0] ROM_INDEX_DEF = 8'd0;
   localparam logic [7:0] DIP_INDEX_DEF = 8'd254;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,  // nothing pending
      HOLD        = 2'd1,  // even (low) byte pending
      ISSUE       = 2'd2,  // waiting for the ack of the last request
      FLUSH_ISSUE = 2'd3   // a strobe is stored and handled once the port is free
   } loader_state_e;

   typedef struct packed {
      logic [23:0] addr;
      logic [15:0] din;
      logic        wrl;
      logic        wrh;
   } pend_wr_t;

   // Wrap-around is intended: the sum is truncated to 24 bits.
   function automatic logic [23:0] word_addr(input logic [24:0] byte_addr,
                                             input logic [23:0] base);
      return byte_addr[24:1] + base;
   endfunction

endpackage

// File: rtl/toggle_req_port.sv
// Toggle req/ack handshake master for one SDRAM port.
// Handshake: a request is outstanding while req_o != ack_i. issue_i is
// accepted only when nothing is outstanding; it toggles req_o and loads the
// write fields in the same cycle. The fields stay held until ack_i == req_o.
// Only one request is ever outstanding.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   issue_i, wr_i  : start a request with the given write fields
//   ack_i          : ack toggle from the SDRAM controller
//   req_o          : request toggle
//   busy_o         : request outstanding
//   wr_o           : held write fields
module toggle_req_port
   import loader_pkg::*;
(
   input  logic     clk_i,
   input  logic     reset_i,
   input  logic     issue_i,
   input  pend_wr_t wr_i,
   input  logic     ack_i,
   output logic     req_o,
   output logic     busy_o,
   output pend_wr_t wr_o
);

   logic     req_q;
   pend_wr_t wr_q;

   assign busy_o = (req_q != ack_i);
   assign req_o  = req_q;
   assign wr_o   = wr_q;

   // req_q is never forced by reset: dropping it would either fake an ack
   // or create a spurious request against the controller's ack toggle.
   // Held fields are cleared only when no request depends on them.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         if (!busy_o) begin
            wr_q <= '0;
         end
      end else if (issue_i && !busy_o) begin
         req_q <= ~req_q;
         wr_q  <= wr_i;
      end
   end

endmodule

// File: rtl/ioctl_sdram_loader.sv
// Bridges the hps_io byte download stream to a 16-bit toggle-handshake
// SDRAM write port, packing even/odd byte pairs into word writes, and
// captures DIP-switch bytes into a register bank.
// Optional feature macro: LOADER_CHECKSUM_EN adds checksum[15:0], the
// wrap-around sum of all accepted ROM bytes.
// Ports:
//   clk_sys, reset                : clock, synchronous active-high reset
//   ioctl_download/index/wr/addr/dout : hps_io download stream
//   ioctl_wait                    : stall request back to hps_io
//   sdr_addr/din/wrl/wrh/req      : SDRAM write request (toggle req)
//   sdr_ack                       : ack toggle from the SDRAM controller
//   dip_sw                        : DIP bytes, byte n at [8n+7:8n]
//   rom_loaded                    : ROM download finished and fully written
module ioctl_sdram_loader
   import loader_pkg::*;
#(
   parameter logic [7:0]  ROM_INDEX = ROM_INDEX_DEF,
   parameter logic [7:0]  DIP_INDEX = DIP_INDEX_DEF,
   parameter int          DIP_BYTES = 8,
   parameter logic [24:0] ROM_LIMIT = 25'h1000000,
   parameter logic [23:0] SDR_BASE  = 24'h000000
) (
   input  logic                   clk_sys,
   input  logic                   reset,
   input  logic                   ioctl_download,
   input  logic [7:0]             ioctl_index,
   input  logic                   ioctl_wr,
   input  logic [24:0]            ioctl_addr,
   input  logic [7:0]             ioctl_dout,
   output logic                   ioctl_wait,
   output logic [23:0]            sdr_addr,
   output logic [15:0]            sdr_din,
   output logic                   sdr_wrl,
   output logic                   sdr_wrh,
   output logic                   sdr_req,
   input  logic                   sdr_ack,
   output logic [DIP_BYTES*8-1:0] dip_sw,
   output logic                   rom_loaded
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [15:0]            checksum
`endif
);

   loader_state_e state_q, state_d;
   logic          pend_vld_q, pend_vld_d;
   logic [24:0]   pend_addr_q, pend_addr_d;
   logic [7:0]    pend_data_q, pend_data_d;
   logic [24:0]   st_addr_q, st_addr_d;
   logic [7:0]    st_data_q, st_data_d;
   logic          wait_q, wait_d;
   logic          fin_q, fin_d;
   logic          loaded_q, loaded_d;
   logic          dl_q, rom_dl_q;
   logic [DIP_BYTES*8-1:0] dip_q;

   logic          busy, issue, rom_acc, rise, fall, proc_go, contig;
   logic [24:0]   proc_addr;
   logic [7:0]    proc_data;
   pend_wr_t      wr_req, wr_held;

   assign rise    = ioctl_download && !dl_q;
   assign fall    = !ioctl_download && dl_q;
   assign rom_acc = ioctl_wr && (ioctl_index == ROM_INDEX) && (ioctl_addr < ROM_LIMIT);

   // A stored strobe (after a flush, or deferred behind a request still
   // outstanding across a reset) is re-run through the same strobe logic.
   assign proc_addr = (state_q == FLUSH_ISSUE) ? st_addr_q : ioctl_addr;
   assign proc_data = (state_q == FLUSH_ISSUE) ? st_data_q : ioctl_dout;
   assign proc_go   = (rom_acc && (state_q == IDLE || state_q == HOLD)) ||
                      (state_q == FLUSH_ISSUE && !busy);
   assign contig    = pend_vld_q && (proc_addr == pend_addr_q + 25'd1);

   always_comb begin
      state_d     = state_q;
      pend_vld_d  = pend_vld_q;
      pend_addr_d = pend_addr_q;
      pend_data_d = pend_data_q;
      st_addr_d   = st_addr_q;
      st_data_d   = st_data_q;
      wait_d      = wait_q;
      fin_d       = fin_q || (fall && rom_dl_q);
      loaded_d    = loaded_q;
      issue       = 1'b0;
      wr_req      = '0;

      if (rise && ioctl_index == ROM_INDEX) begin
         loaded_d = 1'b0;
         fin_d    = 1'b0;
      end

      if (proc_go) begin
         if ((contig || pend_vld_q || proc_addr[0]) && busy) begin
            // Needs the port but it is still busy: park the strobe.
            st_addr_d = proc_addr;
            st_data_d = proc_data;
            state_d   = FLUSH_ISSUE;
            wait_d    = 1'b1;
         end else if (contig) begin
            issue      = 1'b1;
            wr_req     = '{word_addr(proc_addr, SDR_BASE), {proc_data, pend_data_q}, 1'b1, 1'b1};
            pend_vld_d = 1'b0;
            state_d    = ISSUE;
            wait_d     = 1'b1;
         end else if (pend_vld_q) begin
            // Address jump: write out the lone low byte, keep the new strobe.
            issue      = 1'b1;
            wr_req     = '{word_addr(pend_addr_q, SDR_BASE), {pend_data_q, pend_data_q}, 1'b1, 1'b0};
            pend_vld_d = 1'b0;
            st_addr_d  = proc_addr;
            st_data_d  = proc_data;
            state_d    = FLUSH_ISSUE;
            wait_d     = 1'b1;
         end else if (!proc_addr[0]) begin
            pend_vld_d  = 1'b1;
            pend_addr_d = proc_addr;
            pend_data_d = proc_data;
            state_d     = HOLD;
            wait_d      = 1'b0;
         end else begin
            issue   = 1'b1;
            wr_req  = '{word_addr(proc_addr, SDR_BASE), {proc_data, proc_data}, 1'b0, 1'b1};
            state_d = ISSUE;
            wait_d  = 1'b1;
         end
      end else begin
         case (state_q)
            IDLE, HOLD: begin
               if (fin_d && pend_vld_q && !busy) begin
                  issue      = 1'b1;
                  wr_req     = '{word_addr(pend_addr_q, SDR_BASE), {pend_data_q, pend_data_q}, 1'b1, 1'b0};
                  pend_vld_d = 1'b0;
                  state_d    = ISSUE;
                  wait_d     = 1'b1;
               end
            end
            ISSUE: begin
               if (!busy) begin
                  state_d = pend_vld_q ? HOLD : IDLE;
                  wait_d  = 1'b0;
               end
            end
            default: ;
         endcase
      end

      // Download finished and the last write is acked.
      if (fin_d && state_d == IDLE && !pend_vld_d && !busy && !issue) begin
         loaded_d = 1'b1;
         fin_d    = 1'b0;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q     <= IDLE;
         pend_vld_q  <= 1'b0;
         pend_addr_q <= '0;
         pend_data_q <= '0;
         st_addr_q   <= '0;
         st_data_q   <= '0;
         wait_q      <= 1'b0;
         fin_q       <= 1'b0;
         loaded_q    <= 1'b0;
         dl_q        <= 1'b0;
         rom_dl_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_vld_q  <= pend_vld_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
         st_addr_q   <= st_addr_d;
         st_data_q   <= st_data_d;
         wait_q      <= wait_d;
         fin_q       <= fin_d;
         loaded_q    <= loaded_d;
         dl_q        <= ioctl_download;
         if (rise) begin
            rom_dl_q <= (ioctl_index == ROM_INDEX);
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         dip_q <= '1;
      end else if (ioctl_wr && ioctl_index == DIP_INDEX && ioctl_addr < 25'(DIP_BYTES)) begin
         for (int i = 0; i < DIP_BYTES; i++) begin
            if (ioctl_addr[2:0] == 3'(i)) begin
               dip_q[8*i +: 8] <= ioctl_dout;
            end
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [15:0] csum_q;
   always_ff @(posedge clk_sys) begin
      if (reset || (rise && ioctl_index == ROM_INDEX)) begin
         csum_q <= '0;
      end else if (rom_acc) begin
         csum_q <= csum_q + {8'h00, ioctl_dout};
      end
   end
   assign checksum = csum_q;
`endif

   toggle_req_port u_port (
      .clk_i   (clk_sys),
      .reset_i (reset),
      .issue_i (issue),
      .wr_i    (wr_req),
      .ack_i   (sdr_ack),
      .req_o   (sdr_req),
      .busy_o  (busy),
      .wr_o    (wr_held)
   );

   assign sdr_addr   = wr_held.addr;
   assign sdr_din    = wr_held.din;
   assign sdr_wrl    = wr_held.wrl;
   assign sdr_wrh    = wr_held.wrh;
   assign ioctl_wait = wait_q;
   assign dip_sw     = dip_q;
   assign rom_loaded = loaded_q;

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Directed bench for ioctl_sdram_loader with a write scoreboard.
module tb_ioctl_sdram_loader;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic [23:0] sdr_addr;
   logic [15:0] sdr_din;
   logic        sdr_wrl;
   logic        sdr_wrh;
   logic        sdr_req;
   logic        sdr_ack;
   logic [63:0] dip_sw;
   logic        rom_loaded;
`ifdef LOADER_CHECKSUM_EN
   logic [15:0] checksum;
`endif

   always #5 clk_sys = ~clk_sys;

   ioctl_sdram_loader dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .sdr_addr       (sdr_addr),
      .sdr_din        (sdr_din),
      .sdr_wrl        (sdr_wrl),
      .sdr_wrh        (sdr_wrh),
      .sdr_req        (sdr_req),
      .sdr_ack        (sdr_ack),
      .dip_sw         (dip_sw),
      .rom_loaded     (rom_loaded)
`ifdef LOADER_CHECKSUM_EN
      ,
      .checksum       (checksum)
`endif
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          wr_cnt   = 0;
   logic        req_prev = 1'b0;
   logic [41:0] exp_q[$];
   int          wc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [41:0] wr_word(input logic [23:0] a, input logic [15:0] d,
                                           input logic l, input logic h);
      return {a, d, l, h};
   endfunction

   // Count request toggles just after each clock edge.
   always @(posedge clk_sys) begin
      #1;
      if (sdr_req !== req_prev) wr_cnt++;
      req_prev = sdr_req;
   end

   task automatic strobe(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
      @(negedge clk_sys);
      check("no_strobe_while_wait", ioctl_wait, 1'b0);
      ioctl_index = idx;
      ioctl_addr  = a;
      ioctl_dout  = d;
      ioctl_wr    = 1'b1;
      @(negedge clk_sys);
      ioctl_wr    = 1'b0;
   endtask

   // Wait for an outstanding request, score its fields, then ack after n
   // more cycles while counting the cycles ioctl_wait is high.
   task automatic ack_after(input string tag, input int n, output int wait_cyc);
      int t = 0;
      logic [41:0] exp;
      wait_cyc = 0;
      while (sdr_req == sdr_ack && t < 50) begin
         @(negedge clk_sys);
         t++;
      end
      if (sdr_req == sdr_ack) begin
         check({tag, "_timeout"}, sdr_req != sdr_ack, 1'b1);
         return;
      end
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check(tag, {sdr_addr, sdr_din, sdr_wrl, sdr_wrh}, exp);
      repeat (n) begin
         if (ioctl_wait) wait_cyc++;
         @(negedge clk_sys);
      end
      if (ioctl_wait) wait_cyc++;
      sdr_ack = ~sdr_ack;
      @(negedge clk_sys);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
      ioctl_addr = '0; ioctl_dout = '0; sdr_ack = 1'b0;
      repeat (3) @(negedge clk_sys);
      check("rst_wait", ioctl_wait, 1'b0);
      check("rst_req", sdr_req, 1'b0);
      check("rst_wrl_wrh", {sdr_wrl, sdr_wrh}, 2'b00);
      check("rst_din", sdr_din, 16'h0);
      check("rst_addr", sdr_addr, 24'h0);
      check("rst_loaded", rom_loaded, 1'b0);
      check("rst_dip", dip_sw, 64'hFFFF_FFFF_FFFF_FFFF);
      reset = 1'b0;
      ioctl_download = 1'b1;
      @(negedge clk_sys);

      // Byte pair packed into one word write.
      strobe(8'd0, 25'd0, 8'h11);
      check("hold_no_wait", ioctl_wait, 1'b0);
      check("hold_no_write", wr_cnt, 0);
      exp_q.push_back(wr_word(24'd0, 16'h2211, 1'b1, 1'b1));
      strobe(8'd0, 25'd1, 8'h22);
      ack_after("t1_word", 5, wc);
      check("t1_wait_cycles", wc, 6);
      check("t1_wait_low", ioctl_wait, 1'b0);
      check("t1_write_count", wr_cnt, 1);

      // Address jump flushes the lone low byte; the new byte stays pending.
      exp_q.push_back(wr_word(24'd2, 16'hAAAA, 1'b1, 1'b0));
      strobe(8'd0, 25'd4, 8'hAA);
      strobe(8'd0, 25'd10, 8'hBB);
      ack_after("t2_flush", 2, wc);
      check("t2_wait_low", ioctl_wait, 1'b0);
      repeat (3) @(negedge clk_sys);
      check("t2_no_second_write", wr_cnt, 2);
      exp_q.push_back(wr_word(24'd5, 16'hCCBB, 1'b1, 1'b1));
      strobe(8'd0, 25'd11, 8'hCC);
      ack_after("t2_word", 1, wc);

      // Odd byte with nothing pending: high byte only.
      exp_q.push_back(wr_word(24'd3, 16'h5C5C, 1'b0, 1'b1));
      strobe(8'd0, 25'd7, 8'h5C);
      ack_after("t3_high", 1, wc);
      check("t3_wait_cycles", wc, 2);

      // ROM_LIMIT boundary and foreign index.
      strobe(8'd0, 25'h1000000, 8'h77);
      @(negedge clk_sys);
      check("limit_no_write", wr_cnt, 4);
      check("limit_no_wait", ioctl_wait, 1'b0);
      exp_q.push_back(wr_word(24'h7FFFFF, 16'h6666, 1'b0, 1'b1));
      strobe(8'd0, 25'hFFFFFF, 8'h66);
      ack_after("limit_last_byte", 1, wc);
      strobe(8'd5, 25'd3, 8'h99);
      @(negedge clk_sys);
      check("other_index_no_write", wr_cnt, 5);
      check("other_index_no_wait", ioctl_wait, 1'b0);

      // Download end flushes the pending byte, then rom_loaded sets.
      strobe(8'd0, 25'd8, 8'h33);
      check("t4_pending_no_write", wr_cnt, 5);
      ioctl_download = 1'b0;
      check("t4_not_loaded_early", rom_loaded, 1'b0);
      exp_q.push_back(wr_word(24'd4, 16'h3333, 1'b1, 1'b0));
      ack_after("t4_flush", 1, wc);
      check("t4_loaded", rom_loaded, 1'b1);
      check("t4_wait_low", ioctl_wait, 1'b0);

      // DIP bank.
      ioctl_index = 8'd254;
      @(negedge clk_sys);
      ioctl_download = 1'b1;
      strobe(8'd254, 25'd0, 8'hFE);
      strobe(8'd254, 25'd1, 8'h7F);
      strobe(8'd254, 25'd9, 8'h01);
      strobe(8'd254, 25'd8, 8'h00);
      @(negedge clk_sys);
      check("dip_byte0", dip_sw[7:0], 8'hFE);
      check("dip_byte1", dip_sw[15:8], 8'h7F);
      check("dip_rest", dip_sw[63:16], 48'hFFFF_FFFF_FFFF);
      check("dip_no_write", wr_cnt, 6);
      check("dip_keeps_loaded", rom_loaded, 1'b1);
      ioctl_download = 1'b0;
      @(negedge clk_sys);

      // New ROM download clears rom_loaded; reset while a request is out.
      ioctl_index = 8'd0;
      @(negedge clk_sys);
      ioctl_download = 1'b1;
      @(negedge clk_sys);
      check("t6_loaded_cleared", rom_loaded, 1'b0);
      strobe(8'd0, 25'd3, 8'h44);
      check("t6_outstanding", sdr_req != sdr_ack, 1'b1);
      reset = 1'b1;
      @(negedge clk_sys);
      reset = 1'b0;
      check("rst_mid_wait_low", ioctl_wait, 1'b0);
      check("rst_mid_req_held", sdr_req != sdr_ack, 1'b1);
      check("rst_mid_fields_held", {sdr_addr, sdr_din, sdr_wrl, sdr_wrh},
            wr_word(24'd1, 16'h4444, 1'b0, 1'b1));
      repeat (2) @(negedge clk_sys);
      check("rst_mid_no_toggle", wr_cnt, 7);
      sdr_ack = ~sdr_ack;
      @(negedge clk_sys);
      check("rst_mid_ack_done", sdr_req == sdr_ack, 1'b1);
      exp_q.push_back(wr_word(24'd0, 16'h02FF, 1'b1, 1'b1));
      strobe(8'd0, 25'd0, 8'hFF);
      strobe(8'd0, 25'd1, 8'h02);
      ack_after("t6_word_after_reset", 1, wc);
      check("t6_write_count", wr_cnt, 8);
`ifdef LOADER_CHECKSUM_EN
      check("checksum", checksum, 16'h0101);
`endif
      ioctl_download = 1'b0;
      repeat (2) @(negedge clk_sys);
      check("t6_loaded", rom_loaded, 1'b1);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
